// File: rtl/db_switch_ctrl.sv
// Double-buffer sequencer: gates host writes and consumer reads into the core
// and pulses switch_db once the fill bank is full and the drain bank is served.
module db_switch_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             flush,
   input  logic [CNT_W-1:0] depth,
   input  logic [CNT_W-1:0] iter_cnt,
   input  logic             wen_req,
   output logic             wen_ready,
   output logic             wen_out,
   input  logic             ren_req,
   output logic             ren_ready,
   output logic             ren_out,
   output logic             switch_db,
   output logic             bank_sel,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [1:0]       state
);

   localparam logic [1:0] S_FILL   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_SWITCH = 2'd2;

   logic [CNT_W-1:0] cfg_depth;
   logic [CNT_W-1:0] cfg_iter;
   logic [CNT_W:0]   wr_ext;
   logic [CNT_W:0]   rd_ext;
   logic [CNT_W:0]   dep_ext;
   logic [CNT_W:0]   itr_ext;
   logic [CNT_W:0]   wr_nxt;
   logic [CNT_W:0]   rd_nxt;
   logic             acc_w;
   logic             acc_r;
   logic             done_w;
   logic             done_r;
   logic [1:0]       state_nxt;

   // One extra bit keeps cnt+1 from wrapping at the largest config value
   assign wr_ext  = {1'b0, wr_cnt};
   assign rd_ext  = {1'b0, rd_cnt};
   assign dep_ext = {1'b0, cfg_depth};
   assign itr_ext = {1'b0, cfg_iter};

   always_comb begin
      wen_ready = 1'b0;
      ren_ready = 1'b0;
      case (state)
         S_FILL: begin
            wen_ready = (wr_ext < dep_ext);
         end
         S_STREAM: begin
            wen_ready = (wr_ext < dep_ext);
            ren_ready = (rd_ext < itr_ext);
         end
         default: begin
            wen_ready = 1'b0;
            ren_ready = 1'b0;
         end
      endcase
   end

   assign acc_w   = wen_req & wen_ready & clk_en;
   assign acc_r   = ren_req & ren_ready & clk_en;
   assign wen_out = acc_w;
   assign ren_out = acc_r;

   assign wr_nxt = wr_ext + {{CNT_W{1'b0}}, acc_w};
   assign rd_nxt = rd_ext + {{CNT_W{1'b0}}, acc_r};
   assign done_w = (wr_nxt == dep_ext);
   assign done_r = (rd_nxt == itr_ext);

   always_comb begin
      state_nxt = state;
      case (state)
         S_FILL: begin
            if (done_w && (cfg_depth != '0))
               state_nxt = S_SWITCH;
         end
         S_STREAM: begin
            if (done_w && done_r)
               state_nxt = S_SWITCH;
         end
         S_SWITCH: begin
            state_nxt = S_STREAM;
         end
         default: begin
            state_nxt = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || (clk_en && flush)) begin
         state     <= S_FILL;
         switch_db <= 1'b0;
         bank_sel  <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         cfg_depth <= '0;
         cfg_iter  <= '0;
      end else if (clk_en) begin
         state     <= state_nxt;
         switch_db <= (state_nxt == S_SWITCH);
         // Config is only taken while the fill bank is still empty
         if ((state == S_FILL) && (wr_cnt == '0)) begin
            cfg_depth <= depth;
            cfg_iter  <= iter_cnt;
         end
         if (state == S_SWITCH) begin
            bank_sel <= ~bank_sel;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
         end else begin
            wr_cnt <= wr_cnt + CNT_W'(acc_w);
            rd_cnt <= rd_cnt + CNT_W'(acc_r);
         end
      end
   end

endmodule

// File: tb/tb_db_switch_ctrl.sv
// Directed bench for db_switch_ctrl: fill, stream, unequal completion,
// clk_en gating, flush/reconfig and zero-config cases.
module tb_db_switch_ctrl;

   localparam int CNT_W = 16;

   logic             clk;
   logic             reset;
   logic             clk_en;
   logic             flush;
   logic [CNT_W-1:0] depth;
   logic [CNT_W-1:0] iter_cnt;
   logic             wen_req;
   logic             wen_ready;
   logic             wen_out;
   logic             ren_req;
   logic             ren_ready;
   logic             ren_out;
   logic             switch_db;
   logic             bank_sel;
   logic [CNT_W-1:0] wr_cnt;
   logic [CNT_W-1:0] rd_cnt;
   logic [1:0]       state;

   int checks = 0;
   int errors = 0;

   db_switch_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .flush     (flush),
      .depth     (depth),
      .iter_cnt  (iter_cnt),
      .wen_req   (wen_req),
      .wen_ready (wen_ready),
      .wen_out   (wen_out),
      .ren_req   (ren_req),
      .ren_ready (ren_ready),
      .ren_out   (ren_out),
      .switch_db (switch_db),
      .bank_sel  (bank_sel),
      .wr_cnt    (wr_cnt),
      .rd_cnt    (rd_cnt),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Flush, then spend one idle cycle so the new config is latched
   task automatic restart(input int d, input int i);
      flush    = 1'b1;
      depth    = CNT_W'(d);
      iter_cnt = CNT_W'(i);
      wen_req  = 1'b0;
      ren_req  = 1'b0;
      #1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_state", 32'(state), 0);
      chk("flush_bank", 32'(bank_sel), 0);
      chk("flush_wr", 32'(wr_cnt), 0);
      chk("flush_rd", 32'(rd_cnt), 0);
      chk("flush_sw", 32'(switch_db), 0);
      chk("flush_wrdy", 32'(wen_ready), 0);
      tick();
   endtask

   task automatic fill_phase(input int d);
      wen_req = 1'b1;
      ren_req = 1'b1;
      for (int k = 0; k < d; k++) begin
         #1;
         chk("fill_state", 32'(state), 0);
         chk("fill_wr", 32'(wr_cnt), 32'(k));
         chk("fill_wen", 32'(wen_out), 1);
         chk("fill_rrdy", 32'(ren_ready), 0);
         chk("fill_ren", 32'(ren_out), 0);
         tick();
      end
      #1;
      chk("fsw_state", 32'(state), 2);
      chk("fsw_sw", 32'(switch_db), 1);
      chk("fsw_wrdy", 32'(wen_ready), 0);
      chk("fsw_rrdy", 32'(ren_ready), 0);
      chk("fsw_wen", 32'(wen_out), 0);
      tick();
   endtask

   task automatic stream_period(input int d, input int i, input int bank);
      int m;
      m = (d > i) ? d : i;
      wen_req = 1'b1;
      ren_req = 1'b1;
      for (int k = 0; k < m; k++) begin
         #1;
         chk("st_state", 32'(state), 1);
         chk("st_bank", 32'(bank_sel), 32'(bank));
         chk("st_wr", 32'(wr_cnt), 32'((k < d) ? k : d));
         chk("st_rd", 32'(rd_cnt), 32'((k < i) ? k : i));
         chk("st_wen", 32'(wen_out), 32'(k < d));
         chk("st_ren", 32'(ren_out), 32'(k < i));
         chk("st_sw", 32'(switch_db), 0);
         tick();
      end
      #1;
      chk("ssw_state", 32'(state), 2);
      chk("ssw_sw", 32'(switch_db), 1);
      chk("ssw_wrdy", 32'(wen_ready), 0);
      chk("ssw_rrdy", 32'(ren_ready), 0);
      chk("ssw_ren", 32'(ren_out), 0);
      tick();
   endtask

   initial begin
      reset    = 1'b1;
      clk_en   = 1'b1;
      flush    = 1'b0;
      depth    = 16'd4;
      iter_cnt = 16'd4;
      wen_req  = 1'b0;
      ren_req  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_wr", 32'(wr_cnt), 0);
      chk("rst_rd", 32'(rd_cnt), 0);
      chk("rst_bank", 32'(bank_sel), 0);
      chk("rst_sw", 32'(switch_db), 0);
      chk("rst_wen", 32'(wen_out), 0);
      chk("rst_ren", 32'(ren_out), 0);
      chk("rst_wrdy", 32'(wen_ready), 0);
      tick();

      // First fill after reset
      fill_phase(4);
      #1;
      chk("f1_state", 32'(state), 1);
      chk("f1_bank", 32'(bank_sel), 1);
      chk("f1_wr", 32'(wr_cnt), 0);
      chk("f1_rd", 32'(rd_cnt), 0);
      chk("f1_sw", 32'(switch_db), 0);

      // Steady stream, 10-cycle period
      restart(9, 9);
      fill_phase(9);
      stream_period(9, 9, 1);
      stream_period(9, 9, 0);
      stream_period(9, 9, 1);
      #1;
      chk("ss_bank", 32'(bank_sel), 0);

      // Reads finish first, then writes finish first
      restart(4, 2);
      fill_phase(4);
      stream_period(4, 2, 1);
      restart(2, 4);
      fill_phase(2);
      stream_period(2, 4, 1);

      // clk_en gating in STREAM and in SWITCH
      restart(4, 4);
      fill_phase(4);
      wen_req = 1'b1;
      ren_req = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("ce_wr", 32'(wr_cnt), 32'(k));
         tick();
      end
      clk_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("ce0_wen", 32'(wen_out), 0);
         chk("ce0_ren", 32'(ren_out), 0);
         chk("ce0_wr", 32'(wr_cnt), 2);
         chk("ce0_rd", 32'(rd_cnt), 2);
         chk("ce0_state", 32'(state), 1);
         chk("ce0_wrdy", 32'(wen_ready), 1);
         chk("ce0_rrdy", 32'(ren_ready), 1);
         tick();
      end
      clk_en = 1'b1;
      for (int k = 2; k < 4; k++) begin
         #1;
         chk("ce1_wr", 32'(wr_cnt), 32'(k));
         chk("ce1_wen", 32'(wen_out), 1);
         tick();
      end
      clk_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("cesw_state", 32'(state), 2);
         chk("cesw_sw", 32'(switch_db), 1);
         chk("cesw_bank", 32'(bank_sel), 1);
         chk("cesw_wen", 32'(wen_out), 0);
         tick();
      end
      clk_en = 1'b1;
      #1;
      chk("cesw_last", 32'(switch_db), 1);
      tick();
      #1;
      chk("ceend_bank", 32'(bank_sel), 0);
      chk("ceend_state", 32'(state), 1);
      chk("ceend_sw", 32'(switch_db), 0);
      chk("ceend_wr", 32'(wr_cnt), 0);
      tick();
      #1;
      chk("ceend_bank2", 32'(bank_sel), 0);
      chk("ceend_wr2", 32'(wr_cnt), 1);

      // Flush mid-STREAM with a reconfig 4 -> 3
      restart(4, 4);
      fill_phase(4);
      depth = 16'd3;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("fl_wr", 32'(wr_cnt), 32'(k));
         tick();
      end
      restart(3, 4);
      fill_phase(3);
      #1;
      chk("fl3_state", 32'(state), 1);
      chk("fl3_bank", 32'(bank_sel), 1);

      // depth = 0 deadlocks in FILL
      restart(0, 4);
      wen_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("z_wen", 32'(wen_out), 0);
         chk("z_state", 32'(state), 0);
         chk("z_wr", 32'(wr_cnt), 0);
         tick();
      end

      // iter_cnt = 0: writes alone drive the switch
      restart(2, 0);
      fill_phase(2);
      stream_period(2, 0, 1);
      stream_period(2, 0, 0);

      // Reset wins over a deasserted clk_en
      wen_req = 1'b1;
      tick();
      clk_en = 1'b0;
      reset  = 1'b1;
      #1;
      tick();
      reset  = 1'b0;
      clk_en = 1'b1;
      wen_req = 1'b0;
      ren_req = 1'b0;
      #1;
      chk("rp_state", 32'(state), 0);
      chk("rp_bank", 32'(bank_sel), 0);
      chk("rp_wr", 32'(wr_cnt), 0);
      chk("rp_rd", 32'(rd_cnt), 0);
      chk("rp_wrdy", 32'(wen_ready), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/db_switch_ctrl.md
Name: db_switch_ctrl

Overview:
- Sequencer for the double-buffered memory core.
- Gates host write requests and consumer read requests into `wen`/`ren` for the core, and counts words written into the fill bank and reads issued from the drain bank.
- Issues a one-cycle `switch_db` pulse when the fill bank holds `depth` words and the drain bank has served `iter_cnt` reads.
- Sits between the tile-level handshake and the memory core's `wen_in`/`ren_in`/`switch_db` ports.

Parameters:
- `CNT_W`, 16: width of `depth`, `iter_cnt` and the internal counters.

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `clk_en` input 1: global clock enable; when 0, all state is frozen.
- `flush` input 1: synchronous restart to FILL; `depth`/`iter_cnt` are re-latched.
- `depth` input CNT_W: words per buffer (configuration).
- `iter_cnt` input CNT_W: reads per buffer (configuration).
- `wen_req` input 1: host has a write word.
- `wen_ready` output 1: controller can accept a write this cycle.
- `wen_out` output 1: write strobe to core.
- `ren_req` input 1: consumer requests a read.
- `ren_ready` output 1: controller can accept a read this cycle.
- `ren_out` output 1: read strobe to core.
- `switch_db` output 1: bank-swap pulse to core.
- `bank_sel` output 1: index of the current fill (write) bank.
- `wr_cnt` output CNT_W: words written into the fill bank.
- `rd_cnt` output CNT_W: reads issued from the drain bank.
- `state` output 2: 0 = FILL, 1 = STREAM, 2 = SWITCH.

Behaviour:
- **Reset:**
  - `reset` is synchronous, active-high, and has priority over `flush` and `clk_en`.
  - After reset: `state` = FILL, `wr_cnt` = 0, `rd_cnt` = 0, `bank_sel` = 0, `switch_db` = 0, `wen_out` = 0, `ren_out` = 0, and the config registers are cleared to 0.
- **flush:** when `reset` = 0, `flush` = 1 and `clk_en` = 1, the block takes the same values as reset on the next edge. `flush` is ignored when `clk_en` = 0.
- **Config latch:**
  - `cfg_depth` and `cfg_iter` capture `depth` and `iter_cnt` on every enabled edge while `state` = FILL and `wr_cnt` = 0.
  - They are held at all other times; input changes mid-operation have no effect.
- **Accept rules:**
  - `acc_w` = `wen_req` & `wen_ready` & `clk_en`, and `wen_out` = `acc_w`.
  - `acc_r` = `ren_req` & `ren_ready` & `clk_en`, and `ren_out` = `acc_r`.
  - Both strobes are combinational, with zero latency from the request.
- **FILL:**
  - `wen_ready` = (`wr_cnt` < `cfg_depth`); `ren_ready` = 0.
  - `wr_cnt` increments on `acc_w`.
  - When the post-update count `wr_cnt` + `acc_w` equals `cfg_depth` and `cfg_depth` ≠ 0: go to SWITCH.
- **STREAM:**
  - `wen_ready` = (`wr_cnt` < `cfg_depth`); `ren_ready` = (`rd_cnt` < `cfg_iter`).
  - Counters increment independently on their accepts; simultaneous accepts are both counted.
  - `done` = (`wr_cnt` + `acc_w` == `cfg_depth`) && (`rd_cnt` + `acc_r` == `cfg_iter`). When `done`: go to SWITCH.
  - The final write and final read may land in the same cycle or in either order.
- **SWITCH (exactly one enabled cycle):**
  - `switch_db` = 1; `wen_ready` = 0; `ren_ready` = 0.
  - On the next enabled edge: `bank_sel` toggles, `wr_cnt` = 0, `rd_cnt` = 0, `state` = STREAM.
  - The SWITCH cycle is a mandatory one-cycle bubble.
- **`switch_db` decode:** `switch_db` is a registered decode of `state` == SWITCH; it stays high for as long as `clk_en` = 0 holds the block in SWITCH.
- **clk_en = 0:**
  - No counter, state or `bank_sel` change.
  - `wen_out` = 0 and `ren_out` = 0.
  - `wen_ready`/`ren_ready` still reflect the current state.
- **Boundary cases:**
  - `cfg_depth` = 0: FILL accepts nothing and never exits (deadlock by configuration; only flush or reset recovers).
  - `cfg_iter` = 0 in STREAM: reads are blocked, and the switch occurs when writes complete.
  - Counters never exceed their limits, because ready is deasserted at the limit.
  - Requests while not ready are ignored, not queued.
- **Width:** compares are done on CNT_W+1 bits so that `cnt`+1 does not wrap at the maximum config value 2^CNT_W−1.

Test Plan:
- **Reset and first fill:** reset, then `depth`=4, `iter_cnt`=4, `wen_req`=1 continuously → `wen_out` high for 4 cycles; `ren_ready`=0 throughout; cycle 5 `switch_db`=1 with both readies 0; cycle 6 `bank_sel`=1, `state`=STREAM, counters 0.
- **Steady stream:** `wen_req`=`ren_req`=1 with `depth`=`iter_cnt`=9 → 9 simultaneous accepts, 1 switch cycle, repeating every 10 cycles; `bank_sel` alternates 1,0,1.
- **Unequal completion:** `depth`=4, `iter_cnt`=2; reads finish at `rd_cnt`=2 → `ren_ready`=0 until the 4th write; SWITCH follows the 4th write. Then swap the roles (writes finish first) → the switch waits for the last read.
- **clk_en gating:** drop `clk_en` for 3 cycles mid-STREAM and during SWITCH → counters and `state` hold; `wen_out`/`ren_out` are 0; `switch_db` stays 1 while frozen in SWITCH; exactly one toggle of `bank_sel` after re-enable.
- **Flush and reconfig:** flush at `wr_cnt`=2 in STREAM with `depth` changed 4→3 → next cycle FILL, `bank_sel`=0, counters 0; FILL completes after 3 writes.
- **Zero config:** `depth`=0 → no `wen_out` ever, `state` stays FILL. `depth`=2, `iter_cnt`=0 → in STREAM, `ren_ready` is always 0 and a switch occurs every 3 cycles with continuous writes.
